// File: rtl/fft_reorder_pkg.sv
// Shared types, sizes and the 9-bit bit-reversal helper for the FFT output reorder stage.
package fft_reorder_pkg;

  localparam int unsigned WIDTH  = 13;
  localparam int unsigned N_PT   = 512;
  localparam int unsigned LANES  = 16;
  localparam int unsigned BEATS  = N_PT / LANES;
  localparam int unsigned BEAT_W = 5;
  localparam int unsigned LANE_W = 4;
  localparam int unsigned BIN_W  = 9;

  typedef logic [BIN_W-1:0]  bin_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_t;

  function automatic bin_t bitrev9(input bin_t x);
    bin_t r;
    r = '0;
    for (int unsigned i = 0; i < BIN_W; i++) begin
      r[i] = x[BIN_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One half of the ping-pong store: beat-indexed 16-lane write, 16-way gather read.
module reorder_bank
  import fft_reorder_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  beat_t wbeat,
  input  cplx_t wdata [LANES],
  input  bin_t  raddr [LANES],
  output cplx_t rdata [LANES]
);

  // Frame storage is intentionally not reset; every frame overwrites all entries before it is read.
  cplx_t mem [BEATS][LANES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        mem[wbeat][l] <= wdata[l];
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      rdata[l] = mem[raddr[l][BIN_W-1:LANE_W]][raddr[l][LANE_W-1:0]];
    end
  end

endmodule

// File: rtl/fft_reorder.sv
// Converts 16-lane bit-reversed FFT output beats to natural bin order via a ping-pong bank pair.
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned N_PT  = 512,
  parameter int unsigned LANES = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din_re [0:LANES-1],
  input  logic signed [WIDTH-1:0] din_im [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_re [0:LANES-1],
  output logic signed [WIDTH-1:0] dout_im [0:LANES-1],
  output logic                    dout_valid,
  output logic                    dout_sof
);

  localparam int unsigned BEATS_L = N_PT / LANES;
  localparam beat_t       LAST    = BEAT_W'(BEATS_L - 1);

  beat_t     wr_cnt;
  logic      wsel;
  rd_state_t state_q, state_d;
  beat_t     rd_cnt_q, rd_cnt_d;
  logic      start_c;
  logic      emit_c;

  cplx_t wdata [fft_reorder_pkg::LANES];
  bin_t  raddr [fft_reorder_pkg::LANES];
  cplx_t rdata0 [fft_reorder_pkg::LANES];
  cplx_t rdata1 [fft_reorder_pkg::LANES];
  cplx_t gather [fft_reorder_pkg::LANES];

  assign start_c = din_valid && (wr_cnt == LAST);

  always_comb begin
    for (int unsigned l = 0; l < fft_reorder_pkg::LANES; l++) begin
      wdata[l].re = din_re[l];
      wdata[l].im = din_im[l];
    end
  end

  // Natural-order bin k = {rd_cnt, lane} lives at bank address bitrev9(k).
  always_comb begin
    for (int unsigned j = 0; j < fft_reorder_pkg::LANES; j++) begin
      raddr[j] = bitrev9({rd_cnt_q, LANE_W'(j)});
    end
  end

  reorder_bank u_bank0 (
    .clk   (clk),
    .we    (din_valid && !wsel),
    .wbeat (wr_cnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata0)
  );

  reorder_bank u_bank1 (
    .clk   (clk),
    .we    (din_valid && wsel),
    .wbeat (wr_cnt),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata1)
  );

  always_comb begin
    for (int unsigned l = 0; l < fft_reorder_pkg::LANES; l++) begin
      gather[l] = wsel ? rdata0[l] : rdata1[l];
    end
  end

  // Write side: frame boundary flips the bank and kicks the reader.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
      wsel   <= 1'b0;
    end else if (din_valid) begin
      wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + BEAT_W'(1);
      if (wr_cnt == LAST) begin
        wsel <= !wsel;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= RD_IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    emit_c   = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (start_c) begin
          state_d  = RD_DRAIN;
          rd_cnt_d = '0;
        end
      end
      RD_DRAIN: begin
        emit_c = 1'b1;
        if (rd_cnt_q == LAST) begin
          rd_cnt_d = '0;
          if (!start_c) begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + BEAT_W'(1);
        end
      end
      default: begin
        state_d  = RD_IDLE;
        rd_cnt_d = '0;
      end
    endcase
  end

  // Output registers; data is forced to zero outside a burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        dout_re[l] <= '0;
        dout_im[l] <= '0;
      end
    end else begin
      dout_valid <= emit_c;
      dout_sof   <= emit_c && (rd_cnt_q == '0);
      for (int unsigned l = 0; l < LANES; l++) begin
        dout_re[l] <= emit_c ? gather[l].re : '0;
        dout_im[l] <= emit_c ? gather[l].im : '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed + randomized bench for fft_reorder against a bin-indexed reference model.
module tb_fft_reorder;

  localparam int W  = 13;
  localparam int NL = 16;
  localparam int NB = 32;
  localparam int PW = W * NL;

  logic                clk;
  logic                rstn;
  logic                din_valid;
  logic signed [W-1:0] din_re  [0:NL-1];
  logic signed [W-1:0] din_im  [0:NL-1];
  logic signed [W-1:0] dout_re [0:NL-1];
  logic signed [W-1:0] dout_im [0:NL-1];
  logic                dout_valid;
  logic                dout_sof;

  fft_reorder dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_valid  (din_valid),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_sof   (dout_sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_c = -1000;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          sof;
    logic [PW-1:0] re;
    logic [PW-1:0] im;
  } exp_t;

  exp_t exp_q[$];

  logic signed [W-1:0] fr_re [NB][NL];
  logic signed [W-1:0] fr_im [NB][NL];

  function automatic int rev9(input int x);
    int r = 0;
    for (int i = 0; i < 9; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_re();
    logic [PW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*W +: W] = dout_re[l];
    return v;
  endfunction

  function automatic logic [PW-1:0] pack_im();
    logic [PW-1:0] v;
    for (int l = 0; l < NL; l++) v[l*W +: W] = dout_im[l];
    return v;
  endfunction

  // Reference: scatter the frame by bin number, then read bins in natural order.
  task automatic push_expected(input int c);
    logic signed [W-1:0] bin_re [512];
    logic signed [W-1:0] bin_im [512];
    exp_t e;
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        bin_re[rev9(16 * b + l)] = fr_re[b][l];
        bin_im[rev9(16 * b + l)] = fr_im[b][l];
      end
    for (int m = 0; m < NB; m++) begin
      e.cyc = c + 2 + m;
      e.sof = (m == 0);
      for (int j = 0; j < NL; j++) begin
        e.re[j*W +: W] = bin_re[16 * m + j];
        e.im[j*W +: W] = bin_im[16 * m + j];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    din_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      din_re[l] = W'($urandom());
      din_im[l] = W'($urandom());
    end
  endtask

  // gap_mode: 0 back-to-back, 1 valid pattern 1,0,0, 2 random gaps.
  task automatic send_frame(input int gap_mode, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0 && gap_mode == 1) begin idle_cycle(); idle_cycle(); end
      if (b > 0 && gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
      @(negedge clk);
      din_valid = 1'b1;
      for (int l = 0; l < NL; l++) begin
        din_re[l] = fr_re[b][l];
        din_im[l] = fr_im[b][l];
      end
      if (b == NB - 1) begin
        assert (cyc - last_c >= NB) else $fatal(1, "stimulus would start a frame mid-drain");
        last_c = cyc;
        push_expected(cyc);
      end
    end
  endtask

  task automatic fill_ramp(input int off);
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        fr_re[b][l] = W'(16 * b + l + off);
        fr_im[b][l] = W'(-(16 * b + l));
      end
  endtask

  task automatic fill_random();
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        fr_re[b][l] = W'($urandom());
        fr_im[b][l] = W'($urandom());
      end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout pending %0d beats, required 0", exp_q.size());
    end
    idle_cycle();
    idle_cycle();
  endtask

  // Output monitor: every valid beat must match the next expected beat at the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (dout_valid === 1'b0) else begin
            errors++;
            $error("FAIL unexpected_beat at cyc %0d got valid=%b required 0", cyc, dout_valid);
          end
        end else begin
          e = exp_q.pop_front();
          checks++;
          assert (cyc === e.cyc) else begin
            errors++;
            $error("FAIL beat_timing got cyc %0d required %0d", cyc, e.cyc);
          end
          checks++;
          assert (dout_sof === e.sof) else begin
            errors++;
            $error("FAIL sof at cyc %0d got %b required %b", cyc, dout_sof, e.sof);
          end
          checks++;
          assert (pack_re() === e.re) else begin
            errors++;
            $error("FAIL data_re at cyc %0d got %h required %h", cyc, pack_re(), e.re);
          end
          checks++;
          assert (pack_im() === e.im) else begin
            errors++;
            $error("FAIL data_im at cyc %0d got %h required %h", cyc, pack_im(), e.im);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        assert (dout_valid === 1'b1) else begin
          errors++;
          $error("FAIL missing_beat at cyc %0d got valid=%b required 1", cyc, dout_valid);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    checks++;
    assert ({dout_valid, dout_sof, pack_re(), pack_im()} === '0) else begin
      errors++;
      $error("FAIL %s got valid=%b sof=%b re=%h im=%h required all 0",
             tag, dout_valid, dout_sof, pack_re(), pack_im());
    end
  endtask

  initial begin
    rstn      = 1'b0;
    din_valid = 1'b0;
    for (int l = 0; l < NL; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1 check_zero("idle");
    end

    // Single ramp frame
    fill_ramp(0);
    send_frame(0, NB);
    idle_cycle();
    wait_drain();

    // Three back-to-back frames
    fill_ramp(0);
    send_frame(0, NB);
    fill_ramp(1000);
    send_frame(0, NB);
    fill_ramp(-1000);
    send_frame(0, NB);
    idle_cycle();
    wait_drain();

    // Gapped 1,0,0 pattern
    fill_ramp(0);
    send_frame(1, NB);
    idle_cycle();
    wait_drain();

    // Random data with random gaps, then back-to-back random frames
    fill_random();
    send_frame(2, NB);
    idle_cycle();
    wait_drain();
    fill_random();
    send_frame(0, NB);
    fill_random();
    send_frame(0, NB);
    idle_cycle();
    wait_drain();

    // Reset at input beat 17 of frame 1 while frame 0 drains
    fill_random();
    send_frame(0, NB);
    fill_random();
    send_frame(0, 17);
    @(negedge clk);
    rstn      = 1'b0;
    din_valid = 1'b0;
    exp_q.delete();
    #1 check_zero("reset_mid_frame");
    repeat (3) begin
      @(negedge clk);
      #1 check_zero("held_reset");
    end
    @(negedge clk);
    rstn   = 1'b1;
    last_c = -1000;
    fill_random();
    send_frame(0, NB);
    idle_cycle();
    wait_drain();

    // Extremes
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        fr_re[b][l] = 13'sd4095;
        fr_im[b][l] = -13'sd4096;
      end
    send_frame(0, NB);
    idle_cycle();
    wait_drain();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
